// File: rtl/fifo_sync_ext.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow errors, synchronous flush and FWFT or registered read.
module fifo_sync_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter bit FWFT       = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        pop_data,
  output logic                         pop_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] AF_THR   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_THR   = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic [AW-1:0]         w_wptr_next;
  logic [AW-1:0]         w_rptr_next;
  logic [CW-1:0]         w_count_next;

  // Acceptance looks only at registered flags, so a pop never frees room for a push in the same cycle.
  assign w_push_acc  = push & ~r_full;
  assign w_pop_acc   = pop & ~r_empty;
  assign w_wptr_next = (r_wptr == PTR_LAST) ? '0 : r_wptr + PTR_ONE;
  assign w_rptr_next = (r_rptr == PTR_LAST) ? '0 : r_rptr + PTR_ONE;

  always_comb begin
    w_count_next = r_count;
    case ({w_push_acc, w_pop_acc})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= (AF_LEVEL <= 0);
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_push_acc) r_wptr <= w_wptr_next;
      if (w_pop_acc)  r_rptr <= w_rptr_next;
      r_count        <= w_count_next;
      r_full         <= (w_count_next == CNT_FULL);
      r_empty        <= (w_count_next == '0);
      r_almost_full  <= (w_count_next >= AF_THR);
      r_almost_empty <= (w_count_next <= AE_THR);
      if (push && r_full)  r_overflow  <= 1'b1;
      if (pop  && r_empty) r_underflow <= 1'b1;
    end
  end

  // Storage is never reset; a flush only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (w_push_acc && !rst && !clear) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign pop_data  = r_mem[r_rptr];
      assign pop_valid = ~r_empty;
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] r_pop_data;
      logic                  r_pop_valid;

      always_ff @(posedge clk) begin
        if (rst || clear) begin
          r_pop_data  <= '0;
          r_pop_valid <= 1'b0;
        end else begin
          r_pop_valid <= w_pop_acc;
          if (w_pop_acc) r_pop_data <= r_mem[r_rptr];
        end
      end

      assign pop_data  = r_pop_data;
      assign pop_valid = r_pop_valid;
    end
  endgenerate

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
